// File: rtl/id_stage_pkg.sv
// Shared decode constants, ALU/forwarding codes and the control bundle
// for the MIPS instruction-decode stage.
package id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } aluc_e;

    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_EXE     = 2'b01,
        FWD_MEM_ALU = 2'b10,
        FWD_MEM_LD  = 2'b11
    } fwd_e;

    typedef struct packed {
        logic  wreg;
        logic  m2reg;
        logic  wmem;
        logic  aluimm;
        logic  shift;
        logic  wz;
        logic  lui;
        logic  use_rs;
        logic  use_rt;
        logic  beq;
        logic  bne;
        logic  jmp;
        logic  rtype;
        aluc_e aluc;
    } ctrl_t;

    function automatic fwd_e fwd_sel(
        input logic       used,
        input logic [4:0] src,
        input logic       e_w,
        input logic       e_m,
        input logic [4:0] e_rn,
        input logic       m_w,
        input logic       m_m,
        input logic [4:0] m_rn
    );
        fwd_e sel;
        sel = FWD_RF;
        if (used && src != 5'd0) begin
            if (e_w && !e_m && e_rn == src)
                sel = FWD_EXE;
            else if (m_w && m_rn == src)
                sel = m_m ? FWD_MEM_LD : FWD_MEM_ALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two async read ports, one write port,
// write-through on the read side and $0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wn,
    input  logic [31:0] i_wd
);

    logic [31:0] r_mem [32];
    logic        w_wr;

    assign w_wr = i_we && (i_wn != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[i_wn] <= i_wd;
        end
    end

    // Bypass the write port so WB and ID can share a cycle.
    assign o_rd1 = (i_ra1 == 5'd0)          ? 32'd0 :
                   (w_wr && i_wn == i_ra1)  ? i_wd  :
                   r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0)          ? 32'd0 :
                   (w_wr && i_wn == i_ra2)  ? i_wd  :
                   r_mem[i_ra2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: decode, operand read, forwarding selects,
// load-use / branch hazards and beq/bne/j resolution.
import id_stage_pkg::*;

module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] pc4,
    input  logic        wb_wreg,
    input  logic [4:0]  wb_rn,
    input  logic [31:0] wb_d,
    input  logic        exe_wreg,
    input  logic        exe_m2reg,
    input  logic [4:0]  exe_rn,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic [4:0]  mem_rn,
    input  logic [31:0] mem_alu,
    output logic        id_wreg,
    output logic        id_m2reg,
    output logic        id_wmem,
    output logic        id_aluimm,
    output logic        id_shift,
    output logic        id_wz,
    output logic [2:0]  id_aluc,
    output logic [31:0] id_a,
    output logic [31:0] id_b,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rn,
    output logic [1:0]  id_adepen,
    output logic [1:0]  id_bdepen,
    output logic        id_btaken,
    output logic        id_stall,
    output logic [31:0] id_bpc,
    output logic [31:0] stall_cnt
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_ra;
    logic [4:0]  w_rn;
    logic [15:0] w_imm16;
    logic [31:0] w_sext;
    ctrl_t       w_ctrl;
    logic [31:0] w_rf_a;
    logic [31:0] w_rf_b;
    fwd_e        w_adep;
    fwd_e        w_bdep;
    logic        w_lu;
    logic        w_br;
    logic        w_bstall;
    logic        w_stall;
    logic        w_e_a, w_e_b;
    logic        w_mld_a, w_mld_b;
    logic        w_mal_a, w_mal_b;
    logic [31:0] w_ca, w_cb;
    logic        w_eq;
    logic        w_take;
    logic [31:0] w_bt;
    logic [31:0] w_jt;
    logic [31:0] r_stall_cnt;

    assign w_op    = inst[31:26];
    assign w_rs    = inst[25:21];
    assign w_rt    = inst[20:16];
    assign w_rd    = inst[15:11];
    assign w_funct = inst[5:0];
    assign w_imm16 = inst[15:0];
    assign w_sext  = {{16{w_imm16[15]}}, w_imm16};

    always_comb begin
        w_ctrl = '0;
        unique case (1'b1)
            (w_op == OP_RTYPE): begin
                w_ctrl.rtype  = 1'b1;
                w_ctrl.wreg   = 1'b1;
                w_ctrl.use_rs = 1'b1;
                w_ctrl.use_rt = 1'b1;
                unique case (1'b1)
                    (w_funct == F_ADD): w_ctrl.aluc = ALU_ADD;
                    (w_funct == F_SUB): w_ctrl.aluc = ALU_SUB;
                    (w_funct == F_AND): w_ctrl.aluc = ALU_AND;
                    (w_funct == F_OR):  w_ctrl.aluc = ALU_OR;
                    (w_funct == F_XOR): w_ctrl.aluc = ALU_XOR;
                    (w_funct == F_SLL),
                    (w_funct == F_SRL),
                    (w_funct == F_SRA): begin
                        w_ctrl.shift  = 1'b1;
                        w_ctrl.use_rs = 1'b0;
                        w_ctrl.aluc   = (w_funct == F_SLL) ? ALU_SLL :
                                        (w_funct == F_SRL) ? ALU_SRL :
                                        ALU_SRA;
                    end
                    default: begin
                        w_ctrl.wreg   = 1'b0;
                        w_ctrl.use_rs = 1'b0;
                        w_ctrl.use_rt = 1'b0;
                    end
                endcase
            end
            (w_op == OP_ADDI),
            (w_op == OP_ANDI),
            (w_op == OP_ORI),
            (w_op == OP_XORI): begin
                w_ctrl.wreg   = 1'b1;
                w_ctrl.aluimm = 1'b1;
                w_ctrl.use_rs = 1'b1;
                w_ctrl.wz     = (w_op != OP_ADDI);
                w_ctrl.aluc   = (w_op == OP_ANDI) ? ALU_AND :
                                (w_op == OP_ORI)  ? ALU_OR  :
                                (w_op == OP_XORI) ? ALU_XOR :
                                ALU_ADD;
            end
            (w_op == OP_LUI): begin
                w_ctrl.wreg   = 1'b1;
                w_ctrl.aluimm = 1'b1;
                w_ctrl.lui    = 1'b1;
            end
            (w_op == OP_LW): begin
                w_ctrl.wreg   = 1'b1;
                w_ctrl.m2reg  = 1'b1;
                w_ctrl.aluimm = 1'b1;
                w_ctrl.use_rs = 1'b1;
            end
            (w_op == OP_SW): begin
                w_ctrl.wmem   = 1'b1;
                w_ctrl.aluimm = 1'b1;
                w_ctrl.use_rs = 1'b1;
                w_ctrl.use_rt = 1'b1;
            end
            (w_op == OP_BEQ),
            (w_op == OP_BNE): begin
                w_ctrl.beq    = (w_op == OP_BEQ);
                w_ctrl.bne    = (w_op == OP_BNE);
                w_ctrl.use_rs = 1'b1;
                w_ctrl.use_rt = 1'b1;
                w_ctrl.aluc   = ALU_SUB;
            end
            (w_op == OP_J): w_ctrl.jmp = 1'b1;
            default: w_ctrl = '0;
        endcase
    end

    assign w_ra = w_ctrl.lui ? 5'd0 : w_rs;
    assign w_rn = w_ctrl.rtype ? w_rd : w_rt;

    regfile u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_ra),
        .i_ra2 (w_rt),
        .o_rd1 (w_rf_a),
        .o_rd2 (w_rf_b),
        .i_we  (wb_wreg),
        .i_wn  (wb_rn),
        .i_wd  (wb_d)
    );

    assign w_adep = fwd_sel(w_ctrl.use_rs, w_ra, exe_wreg, exe_m2reg,
                            exe_rn, mem_wreg, mem_m2reg, mem_rn);
    assign w_bdep = fwd_sel(w_ctrl.use_rt, w_rt, exe_wreg, exe_m2reg,
                            exe_rn, mem_wreg, mem_m2reg, mem_rn);

    assign w_e_a   = w_ctrl.use_rs && w_ra != 5'd0 && exe_wreg && exe_rn == w_ra;
    assign w_e_b   = w_ctrl.use_rt && w_rt != 5'd0 && exe_wreg && exe_rn == w_rt;
    assign w_mld_a = w_ctrl.use_rs && w_ra != 5'd0 && mem_wreg && mem_m2reg
                     && mem_rn == w_ra;
    assign w_mld_b = w_ctrl.use_rt && w_rt != 5'd0 && mem_wreg && mem_m2reg
                     && mem_rn == w_rt;
    assign w_mal_a = w_ctrl.use_rs && w_ra != 5'd0 && mem_wreg && !mem_m2reg
                     && mem_rn == w_ra;
    assign w_mal_b = w_ctrl.use_rt && w_rt != 5'd0 && mem_wreg && !mem_m2reg
                     && mem_rn == w_rt;

    assign w_lu     = exe_m2reg && (w_e_a || w_e_b);
    assign w_br     = w_ctrl.beq || w_ctrl.bne;
    // Branches compare in ID, so any unresolved producer must wait.
    assign w_bstall = w_br && (w_e_a || w_e_b || w_mld_a || w_mld_b);
    assign w_stall  = w_lu || w_bstall;

    assign w_ca   = w_mal_a ? mem_alu : w_rf_a;
    assign w_cb   = w_mal_b ? mem_alu : w_rf_b;
    assign w_eq   = (w_ca == w_cb);
    assign w_take = !w_stall && ((w_ctrl.beq && w_eq) ||
                                 (w_ctrl.bne && !w_eq) || w_ctrl.jmp);
    assign w_bt   = pc4 + {w_sext[29:0], 2'b00};
    assign w_jt   = {pc4[31:28], inst[25:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign id_wreg   = w_ctrl.wreg && (w_rn != 5'd0) && !w_stall;
    assign id_m2reg  = w_ctrl.m2reg && !w_stall;
    assign id_wmem   = w_ctrl.wmem && !w_stall;
    assign id_aluimm = w_ctrl.aluimm;
    assign id_shift  = w_ctrl.shift;
    assign id_wz     = w_ctrl.wz;
    assign id_aluc   = w_ctrl.aluc;
    assign id_a      = w_rf_a;
    assign id_b      = w_rf_b;
    assign id_imm    = w_ctrl.lui ? {w_imm16, 16'h0000} :
                       w_ctrl.wz  ? {16'h0000, w_imm16} :
                       w_sext;
    assign id_rn     = w_rn;
    assign id_adepen = w_adep;
    assign id_bdepen = w_bdep;
    assign id_btaken = w_take;
    assign id_stall  = w_stall;
    assign id_bpc    = w_ctrl.jmp ? w_jt : (w_br ? w_bt : 32'd0);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS pipeline. It sits between the IF/ID register and `id_exe_register`, and owns the 32×32 register file. It decodes the instruction, reads operands, produces forwarding selects, detects load-use and branch hazards, resolves beq/bne/j, and emits the complete control bundle that `id_exe_register` latches each cycle.

## Interface
Parameters:
- RESET_PC_UNUSED – none; the block has no parameters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst  in  32  instruction from IF/ID.
- pc4  in  32  PC+4 of `inst`.
- wb_wreg, wb_rn, wb_d  in  1/5/32  write-back port.
- exe_wreg, exe_m2reg, exe_rn  in  1/1/5  producer currently in EXE.
- mem_wreg, mem_m2reg, mem_rn, mem_alu  in  1/1/5/32  producer currently in MEM, with its ALU result.
- id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_wz  out  1 each  control bundle to `id_exe_register`.
- id_aluc  out  3  ALU op.
- id_a, id_b, id_imm  out  32 each  register-file operands and extended immediate.
- id_rn  out  5  destination register.
- id_adepen, id_bdepen  out  2 each  forwarding selects.
- id_btaken  out  1  branch/jump taken this cycle.
- id_stall  out  1  hold PC and IF/ID; bubble is inserted.
- id_bpc  out  32  redirect target, valid when id_btaken=1.
- stall_cnt  out  32  saturating count of stall cycles.

## Operation
- Supported instructions: add, sub, and, or, xor, sll, srl, sra, addi, andi, ori, xori, lui, lw, sw, beq, bne, j. Any other opcode decodes as a bubble: all write and memory enables are 0.
- id_aluc encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
- lui: id_aluc=add, rs forced to $0, id_imm={imm16,16'b0}.
- Immediate extension: id_imm is sign-extended for addi, lw, sw, beq and bne. It is zero-extended for andi, ori and xori, and id_wz=1 marks the zero-extended case.
- Shifts: id_shift=1; EXE takes the shift amount from id_imm[10:6].
- id_rn: rd for R-type, rt for I-type. id_wreg=0 whenever the destination is $0.
- Register file:
  - $0 always reads 0.
  - Write on the rising clk edge when wb_wreg=1 and wb_rn≠0.
  - Same-cycle write-through: a read of wb_rn returns wb_d.
- Forwarding select for each source (rs→adepen, rt→bdepen; a select is only non-zero when the instruction actually uses that source):
  - 01: exe_wreg, exe_rn matches, exe_m2reg=0.
  - 10: otherwise, mem_wreg, mem_rn matches, mem_m2reg=0.
  - 11: otherwise, mem_wreg, mem_rn matches, mem_m2reg=1.
  - 00: none of the above; use the register-file value.
  - A source of $0 is never forwarded.
- Load-use stall: the EXE producer has exe_m2reg=1 and matches a used source. Then id_stall=1.
- Branch operand stall (beq/bne only): a source matches either an EXE producer (any kind) or a MEM producer with mem_m2reg=1. Then id_stall=1.
- Branch operand bypass: if a source matches a MEM producer with mem_m2reg=0, the comparison uses mem_alu.
- While id_stall=1:
  - id_wreg, id_wmem, id_m2reg and id_btaken are forced to 0.
  - All other outputs keep their decoded values.
- Branch resolution when id_stall=0:
  - beq/bne taken: id_btaken=1, id_bpc = pc4 + (sext(imm16)<<2).
  - j: id_btaken=1, id_bpc = {pc4[31:28], target, 2'b00}.
  - No delay slot; IF flushes when it sees id_btaken.
- stall_cnt increments on every rising edge where id_stall=1, saturating at 0xFFFFFFFF.

## Timing
- Decode, forwarding, hazard and branch outputs are combinational from inst and the hazard inputs. They are sampled by `id_exe_register` at the next rising edge.
- Register-file write happens on the rising edge and is visible in the same cycle through the write-through path.
- Load-use costs exactly one stall cycle. On the next cycle the load is in MEM and the select is 11.
- Branch hazards:
  - On an ALU producer in EXE: one stall cycle, then the mem_alu bypass applies.
  - On a load in EXE: two stall cycles.
- Reset (asynchronous, takes effect immediately, including mid-stall):
  - All register-file entries clear to 0.
  - stall_cnt clears to 0.
  - With inst=0 (sll $0,$0,0), every output reads 0 except id_shift=1 and id_aluc=101.

## Structure
- Shared package:
  - opcode and funct constants;
  - ALU op codes;
  - depen codes FWD_RF=00, FWD_EXE=01, FWD_MEM_ALU=10, FWD_MEM_LD=11.
- Sub-module `regfile`: 2 read ports, 1 write port, asynchronous active-high reset, write-through, $0 hardwired to 0.
- Decode, hazard and branch logic are written inline.

## Test plan
- Write $5=0x1234 via the WB port, then decode `add $6,$5,$5` in the same cycle -> id_a=id_b=0x1234, depen=00/00.
- `lw $2,0($1)` in EXE with `add $3,$2,$4` in ID -> id_stall=1, id_wreg=0, stall_cnt +1. Next cycle, with the load in MEM -> id_adepen=11, id_stall=0.
- `add $7,...` in EXE and `sub $8,$7,$7` in ID -> id_adepen=id_bdepen=01, no stall.
- `beq $1,$2,+4` with $1=$2=9 -> id_btaken=1, id_bpc=pc4+16. With $2=8 -> id_btaken=0.
- beq whose rs is produced by an ALU op in EXE -> one stall cycle, then resolved using mem_alu.
- Assert rst mid-stall -> stall_cnt=0, register file cleared, and $5 reads 0 afterwards.
